// File: rtl/prt_hb_mon.sv
// Heartbeat monitor: synchronises a toggling heartbeat, measures edge-to-edge
// intervals and qualifies the source as alive (LOCK) or lost.
module prt_hb_mon #(
    parameter int unsigned P_BEAT = 100,
    parameter int unsigned P_TOL  = 4,
    parameter int unsigned P_LOCK = 3
) (
    input  logic        CLK_IN,
    input  logic        RSTN_IN,
    input  logic        HB_IN,
    input  logic        CLR_IN,
    output logic        EDGE_OUT,
    output logic        ALIVE_OUT,
    output logic        LOST_OUT,
    output logic [31:0] PERIOD_OUT,
    output logic [15:0] ERR_CNT_OUT
);

    localparam int unsigned P_NOM = P_BEAT + 2;
    localparam logic [31:0] MIN_C = 32'(P_NOM - P_TOL);
    localparam logic [31:0] MAX_C = 32'(P_NOM + P_TOL);
    localparam int unsigned GW    = $clog2(P_LOCK + 1);
    localparam logic [GW-1:0] LOCK_LAST = GW'(P_LOCK - 1);

    typedef enum logic [1:0] {S_IDLE, S_ACQ, S_LOCK, S_LOST} state_e;

    state_e        state_q, state_d;
    logic [1:0]    sync_q;
    logic          hist_q;
    logic [31:0]   cnt_q, cnt_d;
    logic [GW-1:0] good_q, good_d;
    logic          edge_q, alive_q, lost_q, lost_d;
    logic [31:0]   period_q;
    logic [15:0]   err_q;
    logic          edge_w, good_iv, timeout, err_evt, load;

    assign edge_w  = sync_q[1] ^ hist_q;
    assign good_iv = (cnt_q >= MIN_C) && (cnt_q <= MAX_C);
    // cnt passes MAX_C only once per gap and saturation never wraps back,
    // so the timeout fires exactly once.
    assign timeout = !edge_w && (cnt_q == MAX_C) &&
                     ((state_q == S_ACQ) || (state_q == S_LOCK));

    always_comb begin
        cnt_d = edge_w ? 32'd1 :
                (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;
    end

    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        err_evt = 1'b0;
        load    = 1'b0;
        lost_d  = 1'b0;
        case (state_q)
            S_IDLE, S_LOST: begin
                if (edge_w) begin
                    state_d = S_ACQ;
                    good_d  = '0;
                end
            end
            S_ACQ: begin
                if (edge_w) begin
                    load = 1'b1;
                    if (good_iv) begin
                        good_d = good_q + 1'b1;
                        if (good_q == LOCK_LAST) state_d = S_LOCK;
                    end else begin
                        good_d  = '0;
                        err_evt = 1'b1;
                    end
                end else if (timeout) begin
                    state_d = S_IDLE;
                    err_evt = 1'b1;
                end
            end
            S_LOCK: begin
                if (edge_w) begin
                    load = 1'b1;
                    // Long intervals cannot reach here: timeout leaves LOCK first.
                    if (!good_iv) begin
                        state_d = S_ACQ;
                        good_d  = '0;
                        lost_d  = 1'b1;
                        err_evt = 1'b1;
                    end
                end else if (timeout) begin
                    state_d = S_LOST;
                    lost_d  = 1'b1;
                    err_evt = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK_IN or negedge RSTN_IN) begin
        if (!RSTN_IN) begin
            sync_q   <= '0;
            hist_q   <= 1'b0;
            cnt_q    <= '0;
            state_q  <= S_IDLE;
            good_q   <= '0;
            edge_q   <= 1'b0;
            alive_q  <= 1'b0;
            lost_q   <= 1'b0;
            period_q <= '0;
            err_q    <= '0;
        end else begin
            sync_q   <= {sync_q[0], HB_IN};
            hist_q   <= sync_q[1];
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            good_q   <= good_d;
            edge_q   <= edge_w;
            alive_q  <= (state_d == S_LOCK);
            lost_q   <= lost_d;
            if (CLR_IN)      period_q <= '0;
            else if (load)   period_q <= cnt_q;
            if (CLR_IN)      err_q <= '0;
            else if (err_evt && (err_q != 16'hFFFF)) err_q <= err_q + 16'd1;
        end
    end

    assign EDGE_OUT    = edge_q;
    assign ALIVE_OUT   = alive_q;
    assign LOST_OUT    = lost_q;
    assign PERIOD_OUT  = period_q;
    assign ERR_CNT_OUT = err_q;

endmodule

// File: tb/tb_prt_hb_mon.sv
// Randomised scoreboard bench for prt_hb_mon: the model predicts the output
// events from the list of heartbeat toggle gaps; a monitor checks them.
module tb_prt_hb_mon;

    localparam int unsigned P_BEAT = 100, P_TOL = 4, P_LOCK = 3;
    localparam int unsigned P_NOM = P_BEAT + 2;
    localparam int unsigned P_MIN = P_NOM - P_TOL, P_MAX = P_NOM + P_TOL;

    logic        CLK_IN = 1'b0;
    logic        RSTN_IN, HB_IN, CLR_IN;
    logic        EDGE_OUT, ALIVE_OUT, LOST_OUT;
    logic [31:0] PERIOD_OUT;
    logic [15:0] ERR_CNT_OUT;

    prt_hb_mon #(.P_BEAT(P_BEAT), .P_TOL(P_TOL), .P_LOCK(P_LOCK)) dut (
        .CLK_IN(CLK_IN), .RSTN_IN(RSTN_IN), .HB_IN(HB_IN), .CLR_IN(CLR_IN),
        .EDGE_OUT(EDGE_OUT), .ALIVE_OUT(ALIVE_OUT), .LOST_OUT(LOST_OUT),
        .PERIOD_OUT(PERIOD_OUT), .ERR_CNT_OUT(ERR_CNT_OUT)
    );

    always #5 CLK_IN = ~CLK_IN;

    int unsigned cyc = 0;
    always @(posedge CLK_IN) cyc <= cyc + 1;

    typedef struct packed {
        int unsigned cyc;
        logic        edg;
        logic        lost;
        logic        alive;
        logic [31:0] period;
        logic [15:0] err;
    } ev_t;

    ev_t         expq[$];
    int unsigned n_cmp = 0, n_bad = 0;

    // Reference model: locked flag, run of good intervals, tracking flag.
    bit          m_track, m_locked;
    int          m_run, m_err;
    logic [31:0] m_period;
    int unsigned prev_c, last_ev;
    int unsigned clr_at = 32'hFFFF_FFFF;

    task automatic model_reset();
        m_track = 0; m_locked = 0; m_run = 0; m_err = 0; m_period = '0;
        clr_at = 32'hFFFF_FFFF;
    endtask

    task automatic err_inc();
        if (m_err < 65535) m_err = m_err + 1;
    endtask

    // Wait g clocks after the previous toggle, toggle HB_IN, and predict.
    task automatic do_gap(input int unsigned g, input bit clr);
        int unsigned tog;
        bit          lost = 0;
        if (m_track && g > P_MAX) begin
            err_inc();
            if (m_locked)
                expq.push_back(ev_t'{last_ev + P_MAX, 1'b0, 1'b1, 1'b0, m_period, 16'(m_err)});
            m_track = 0; m_locked = 0;
        end
        while (cyc < prev_c + g) @(negedge CLK_IN);
        HB_IN  = ~HB_IN;
        prev_c = cyc;
        tog    = cyc + 1;
        if (clr) clr_at = tog + 1;
        if (!m_track) begin
            m_track = 1; m_run = 0;
        end else begin
            m_period = g;
            if (g >= P_MIN && g <= P_MAX) begin
                m_run = m_run + 1;
                if (m_run >= P_LOCK) m_locked = 1;
            end else begin
                lost = m_locked;
                m_locked = 0; m_run = 0;
                err_inc();
            end
        end
        if (clr) begin m_period = '0; m_err = 0; end
        last_ev = tog + 2;
        expq.push_back(ev_t'{last_ev, 1'b1, lost, m_locked, m_period, 16'(m_err)});
    endtask

    task automatic check_zero(input string nm);
        n_cmp++;
        if ({EDGE_OUT, ALIVE_OUT, LOST_OUT} !== 3'b000 || PERIOD_OUT !== 32'd0 ||
            ERR_CNT_OUT !== 16'd0) begin
            n_bad++;
            $display("FAIL %s: got e=%0b a=%0b l=%0b per=%0d err=%0d, want all 0",
                     nm, EDGE_OUT, ALIVE_OUT, LOST_OUT, PERIOD_OUT, ERR_CNT_OUT);
        end
    endtask

    // CLR_IN pulse on the cycle the DUT acts on the requested edge.
    initial begin
        CLR_IN = 1'b0;
        forever begin
            @(negedge CLK_IN);
            CLR_IN = (cyc == clr_at);
        end
    end

    // Monitor: pops an expected record whenever the DUT presents an event.
    logic alive_exp = 1'b0;
    initial begin
        ev_t got, exp;
        forever begin
            @(negedge CLK_IN);
            if (!RSTN_IN) begin
                alive_exp = 1'b0;
            end else begin
                while (expq.size() > 0 && expq[0].cyc < cyc) begin
                    exp = expq.pop_front();
                    n_cmp++; n_bad++;
                    $display("FAIL missing_event: got nothing at cyc %0d, want edge=%0b lost=%0b",
                             exp.cyc, exp.edg, exp.lost);
                end
                if (EDGE_OUT || LOST_OUT) begin
                    got = ev_t'{cyc, EDGE_OUT, LOST_OUT, ALIVE_OUT, PERIOD_OUT, ERR_CNT_OUT};
                    n_cmp++;
                    if (expq.size() > 0 && expq[0].cyc == cyc) begin
                        exp = expq.pop_front();
                        alive_exp = exp.alive;
                        if (got !== exp) begin
                            n_bad++;
                            $display("FAIL event: got cyc=%0d e=%0b l=%0b a=%0b per=%0d err=%0d, want cyc=%0d e=%0b l=%0b a=%0b per=%0d err=%0d",
                                     got.cyc, got.edg, got.lost, got.alive, got.period, got.err,
                                     exp.cyc, exp.edg, exp.lost, exp.alive, exp.period, exp.err);
                        end
                    end else begin
                        n_bad++;
                        $display("FAIL unexpected_event: got e=%0b l=%0b at cyc %0d, want none",
                                 EDGE_OUT, LOST_OUT, cyc);
                    end
                end
                n_cmp++;
                if (ALIVE_OUT !== alive_exp) begin
                    n_bad++;
                    $display("FAIL alive_level: got %0b at cyc %0d, want %0b", ALIVE_OUT, cyc, alive_exp);
                end
            end
        end
    end

    initial begin
        int unsigned g, r;
        RSTN_IN = 1'b0; HB_IN = 1'b0;
        model_reset();
        repeat (3) @(negedge CLK_IN);
        check_zero("reset_state");
        RSTN_IN = 1'b1;
        prev_c  = cyc;

        // Nominal beat: lock on the 4th edge.
        do_gap(10, 0);
        repeat (5) do_gap(P_NOM, 0);
        // Static heartbeat -> timeout, then relock.
        do_gap(300, 0);
        repeat (4) do_gap(P_NOM, 0);
        // Short interval while locked.
        do_gap(97, 0);
        repeat (4) do_gap(P_NOM, 0);
        // Band edges from ACQ, then a gap of P_MAX+1.
        do_gap(250, 0);
        do_gap(P_MIN, 0); do_gap(P_MAX, 0); do_gap(P_MIN, 0);
        do_gap(P_NOM, 0);
        do_gap(P_MAX + 1, 0);
        // Clear on an error edge.
        do_gap(50, 1);
        repeat (4) do_gap(P_NOM, 0);

        for (int i = 0; i < 80; i++) begin
            r = $urandom_range(0, 9);
            if (r < 6)      g = $urandom_range(96, 108);
            else if (r < 8) g = $urandom_range(3, 97);
            else            g = $urandom_range(107, 200);
            do_gap(g, (g >= 3) && ($urandom_range(0, 7) == 0));
        end

        // Asynchronous reset mid-LOCK.
        repeat (4) do_gap(P_NOM, 0);
        repeat (20) @(negedge CLK_IN);
        #2;
        RSTN_IN = 1'b0; HB_IN = 1'b0;
        #1;
        check_zero("async_reset");
        expq.delete();
        model_reset();
        repeat (3) @(negedge CLK_IN);
        RSTN_IN = 1'b1;
        prev_c  = cyc;
        do_gap(5, 0);
        repeat (4) do_gap(P_NOM, 0);

        // Error counter saturation with 1-clock glitches.
        repeat (65540) do_gap(1, 0);
        repeat (3) do_gap(P_NOM, 0);

        for (int i = 0; i < 400 && expq.size() > 0; i++) @(negedge CLK_IN);
        n_cmp++;
        if (expq.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d events outstanding, want 0", expq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
